// File: rtl/conv_relu_pool.sv
// conv_relu_pool: ReLU, requantise and 2x2 max-pool a 4x4 tile, then stream the 2x2 result
module conv_relu_pool #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8,
  parameter int ROUND = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [0:3][0:3][IN_W-1:0]        c_in,
  input  logic [3:0]                       shift_amt,
  output logic                             busy,
  output logic [0:1][0:1][OUT_W-1:0]       pooled,
  output logic [OUT_W-1:0]                 out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_last,
  output logic                             done
);
  typedef enum logic [1:0] {IDLE, POOL, STREAM, FIN} state_t;
  state_t                       state_q;
  logic [0:3][0:3][IN_W-1:0]    tile_q;
  logic [3:0]                   sh_q;
  logic [3:0]                   k_q;
  logic [1:0]                   s_q;
  logic [OUT_W-1:0]             max_q;
  logic [0:1][0:1][OUT_W-1:0]   pooled_q;
  logic [OUT_W-1:0]             out_data_q;
  logic                         valid_q;
  logic                         last_q;
  logic                         busy_q;
  logic                         done_q;
  logic [IN_W-1:0]              x_d;
  logic [IN_W:0]                r_d;
  logic [IN_W:0]                q_d;
  logic [OUT_W-1:0]             t_d;
  logic [OUT_W-1:0]             m_d;
  logic [1:0]                   sn_d;
  logic [OUT_W-1:0]             nxt_d;
  // k walks windows row-major, elements TL,TR,BL,BR: row={k3,k1}, col={k2,k0}
  always_comb begin
    x_d   = tile_q[{k_q[3], k_q[1]}][{k_q[2], k_q[0]}];
    r_d   = x_d[IN_W-1] ? '0 : {1'b0, x_d};
    q_d   = (r_d + ((ROUND != 0 && sh_q != 4'd0) ? (IN_W+1)'(1) << (sh_q - 4'd1) : '0)) >> sh_q;
    t_d   = (q_d > (IN_W+1)'((1 << OUT_W) - 1)) ? '1 : q_d[OUT_W-1:0];
    m_d   = (k_q[1:0] == 2'd0 || t_d > max_q) ? t_d : max_q;
    sn_d  = valid_q ? s_q + 2'd1 : s_q;
    nxt_d = pooled_q[sn_d[1]][sn_d[0]];
  end
  // tile capture, pooling walk and output stream sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tile_q     <= '0;
      sh_q       <= '0;
      k_q        <= '0;
      s_q        <= '0;
      max_q      <= '0;
      pooled_q   <= '0;
      out_data_q <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            tile_q  <= c_in;
            sh_q    <= shift_amt;
            busy_q  <= 1'b1;
            k_q     <= '0;
            state_q <= POOL;
          end
        end
        POOL: begin
          max_q <= m_d;
          if (k_q[1:0] == 2'd3) pooled_q[k_q[3]][k_q[2]] <= m_d;
          k_q <= k_q + 4'd1;
          if (k_q == 4'd15) begin
            s_q     <= '0;
            state_q <= STREAM;
          end
        end
        STREAM: begin
          if (!valid_q || out_ready) begin
            if (valid_q && s_q == 2'd3) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= FIN;
            end else begin
              valid_q    <= 1'b1;
              out_data_q <= nxt_d;
              last_q     <= sn_d == 2'd3;
              s_q        <= sn_d;
            end
          end
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
  assign busy      = busy_q;
  assign pooled    = pooled_q;
  assign out_data  = out_data_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign done      = done_q;
endmodule

// File: doc/conv_relu_pool.md
Name: conv_relu_pool

Overview:
- Downstream stage of the 4x4 convolution engine. Consumes one 4x4 tile of 16-bit convolution results.
- Applies ReLU, then right-shift requantisation with optional rounding and saturation to 8 bits, then 2x2 max-pooling with stride 2.
- Holds the resulting 2x2 tile in parallel form and streams it out with a valid/ready handshake to the next layer's tile buffer.

Parameters:
- IN_W, 16: width of each input element, interpreted as two's complement.
- OUT_W, 8: width of each pooled output element, unsigned.
- ROUND, 1: 1 = round-half-up before the shift; 0 = truncate.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  tile-valid pulse. Accepted only while busy=0.
- c_in  input  IN_W x [0:3][0:3]  convolution result tile. Sampled on the accept edge only.
- shift_amt  input  4  requantisation right-shift, 0..15. Sampled on the accept edge.
- busy  output  1  high from the accept edge until done.
- pooled  output  OUT_W x [0:1][0:1]  registered pooled tile.
- out_data  output  OUT_W  streamed element.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accept.
- out_last  output  1  high with the 4th streamed element.
- done  output  1  one-cycle pulse after the last transfer.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset (any state, including mid-operation):
  - state=IDLE; busy, done, out_valid, out_last = 0.
  - out_data = 0; all pooled = 0.
  - Captured tile, counters and running max cleared.
- FSM states: IDLE, POOL, STREAM, FIN.
- IDLE:
  - On start=1: copy c_in and shift_amt into internal registers, busy<=1, go to POOL.
- POOL: 16 cycles, counter k=0..15, one element per cycle.
  - Window w=k[3:2] in order (0,0),(0,1),(1,0),(1,1).
  - Element order inside a window: top-left, top-right, bottom-left, bottom-right.
  - Window w covers tile rows 2*wr..2*wr+1 and cols 2*wc..2*wc+1.
- Per-element transform:
  - r = (x<0) ? 0 : x.
  - Shift stage: if shift_amt>0 and ROUND=1, q = (r + 2^(shift_amt-1)) >> shift_amt; otherwise q = r >> shift_amt.
  - Compute q at IN_W+1 bits so the rounding add cannot overflow.
  - Saturation: out = min(q, 2^OUT_W-1).
- Max-pooling:
  - Running max is loaded (not compared) on the first element of each window.
  - On the 4th element, pooled[wr][wc] <= max of the 4 transformed values.
  - Ties keep the value; order does not matter.
  - After k=15, go to STREAM.
- Latency: out_valid rises 17 clk edges after the edge that accepted start.
- STREAM:
  - out_valid=1. out_data = pooled element at stream index s (row-major 0..3).
  - Transfer occurs when out_valid & out_ready on an edge; s increments.
  - out_last=1 when s=3.
  - While out_ready=0, out_data, out_last and out_valid are held stable, indefinitely.
  - After the transfer with s=3: out_valid<=0, go to FIN.
- FIN: done=1 for exactly one cycle, busy<=0, go to IDLE. pooled keeps its values until the next tile's POOL writes.
- start while busy=1 is ignored, with no queuing. A new start is first accepted in the cycle after done.
- c_in and shift_amt may change freely after the accept edge without effect.
- Boundary values:
  - shift_amt=0: no rounding term.
  - All-negative window yields 0.
  - 16'h7FFF with shift_amt=0 saturates to 255.

Test Plan:
- Reset mid-STREAM with out_ready=0 -> next cycle busy=0, out_valid=0, pooled all 0. A fresh start then processes normally.
- Tile c_in[r][c] = 16*r + c, shift_amt=0 -> pooled = {17, 19, 49, 51}.
  - out_valid rises 17 edges after accept.
  - With out_ready=1, four transfers on consecutive edges; out_last only with 51; done pulses the next cycle.
- Window 0 = {-5, -1, -300, 16'h8000}, others {1000, 0, 0, 0}, shift_amt=2, ROUND=1 -> pooled[0][0]=0, other three = 250.
- Rounding: all elements 6, shift_amt=2 -> ROUND=1 gives 2, ROUND=0 gives 1. Elements 16'h7FFF, shift_amt=0 -> 255. Element 16'h7FFF, shift_amt=7 -> 255 (256 saturates).
- Backpressure: out_ready toggles 0,0,1,0,1,1,0,1 -> exactly 4 transfers, data/last stable while stalled, order preserved, done one cycle after the 4th accepted edge.
- start pulsed during POOL with a different tile -> ignored; output matches the first tile. A back-to-back start in the cycle after done is accepted.
